// File: rtl/amba_axi4_stream_fifo.sv
// amba_axi4_stream_fifo
//   Synchronous AXI4-Stream FIFO that buffers one stream between a sink-side
//   port (S_*) and a source-side port (M_*). Every sideband signal is carried
//   through unchanged and in order. A beat accepted at edge N is presented on
//   M_* right after edge N. There is no fall-through path when the FIFO is empty.
//
// Ports
//   ACLK, ARESETn        clock (rising edge), asynchronous active-low reset
//   S_TVALID / S_TREADY  sink-side handshake; S_TREADY is registered
//   S_TDATA..S_TUSER     sink-side payload and sideband
//   M_TVALID / M_TREADY  source-side handshake
//   M_TDATA..M_TUSER     source-side payload and sideband (head of FIFO)
//   LEVEL                number of stored beats (0..DEPTH)
//
// Parameters
//   DATA_WIDTH_BYTES  TDATA bytes; TSTRB/TKEEP width
//   DEST_WIDTH, ID_WIDTH, USER_WIDTH  sideband widths; 0 gives a 1-bit port
//                     that is tied to 0 internally
//   DEPTH             entries; must be a power of 2 and >= 2
//
// Build option
//   AXI4_STREAM_FIFO_PKT_MODE_EN  when defined, selects store-and-forward.
//     M_TVALID is then held low until a whole packet (TLAST beat) is stored.
//     A full FIFO that holds no TLAST beat sets a flush flag. The flag releases
//     the oversized packet and clears when its TLAST beat is popped.
//     When the macro is undefined, the FIFO runs in cut-through mode.

module amba_axi4_stream_fifo #(
  parameter int unsigned DATA_WIDTH_BYTES = 1,
  parameter int unsigned DEST_WIDTH       = 4,
  parameter int unsigned ID_WIDTH         = 8,
  parameter int unsigned USER_WIDTH       = 0,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                                         ACLK,
  input  logic                                         ARESETn,
  input  logic                                         S_TVALID,
  output logic                                         S_TREADY,
  input  logic [8*DATA_WIDTH_BYTES-1:0]                S_TDATA,
  input  logic [DATA_WIDTH_BYTES-1:0]                  S_TSTRB,
  input  logic [DATA_WIDTH_BYTES-1:0]                  S_TKEEP,
  input  logic                                         S_TLAST,
  input  logic [((ID_WIDTH   > 0) ? ID_WIDTH   : 1)-1:0] S_TID,
  input  logic [((DEST_WIDTH > 0) ? DEST_WIDTH : 1)-1:0] S_TDEST,
  input  logic [((USER_WIDTH > 0) ? USER_WIDTH : 1)-1:0] S_TUSER,
  output logic                                         M_TVALID,
  input  logic                                         M_TREADY,
  output logic [8*DATA_WIDTH_BYTES-1:0]                M_TDATA,
  output logic [DATA_WIDTH_BYTES-1:0]                  M_TSTRB,
  output logic [DATA_WIDTH_BYTES-1:0]                  M_TKEEP,
  output logic                                         M_TLAST,
  output logic [((ID_WIDTH   > 0) ? ID_WIDTH   : 1)-1:0] M_TID,
  output logic [((DEST_WIDTH > 0) ? DEST_WIDTH : 1)-1:0] M_TDEST,
  output logic [((USER_WIDTH > 0) ? USER_WIDTH : 1)-1:0] M_TUSER,
  output logic [$clog2(DEPTH+1)-1:0]                   LEVEL
);

  localparam int unsigned DB  = 8 * DATA_WIDTH_BYTES;
  localparam int unsigned SB  = DATA_WIDTH_BYTES;
  localparam int unsigned IDW = (ID_WIDTH   > 0) ? ID_WIDTH   : 1;
  localparam int unsigned DW  = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;
  localparam int unsigned UW  = (USER_WIDTH > 0) ? USER_WIDTH : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = $clog2(DEPTH + 1);
  localparam int unsigned BW  = DB + 2*SB + 1 + IDW + DW + UW;

  logic [BW-1:0]  mem [DEPTH];
  logic [BW-1:0]  wr_word;
  logic [BW-1:0]  rd_word;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_next;
  logic           s_tready;
  logic           ready_en;
  logic           m_tvalid;
  logic           push;
  logic           pop;
  logic [IDW-1:0] id_in;
  logic [DW-1:0]  dest_in;
  logic [UW-1:0]  user_in;

  // Zero-width sidebands are stored as constant 0, whatever the port carries.
  assign id_in   = (ID_WIDTH   > 0) ? S_TID   : '0;
  assign dest_in = (DEST_WIDTH > 0) ? S_TDEST : '0;
  assign user_in = (USER_WIDTH > 0) ? S_TUSER : '0;

  assign wr_word = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, id_in, dest_in, user_in};
  assign rd_word = mem[rd_ptr];
  assign {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER} = rd_word;

  assign push     = S_TVALID & s_tready;
  assign pop      = m_tvalid & M_TREADY;
  assign S_TREADY = s_tready;
  assign M_TVALID = m_tvalid;
  assign LEVEL    = level;

  // Payload storage is not reset. The head entry is never overwritten while
  // it is stored, so M_T* stays stable until the entry is popped.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
    end
  end

  // ready_en keeps S_TREADY low through the first edge after reset release.
  // After that, S_TREADY looks at the next level, so M_TREADY has no
  // combinational path to it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en <= 1'b0;
      s_tready <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      s_tready <= ready_en && (level_next != LW'(DEPTH));
    end
  end

`ifdef AXI4_STREAM_FIFO_PKT_MODE_EN
  logic [LW-1:0] pkt_cnt;
  logic          flush;
  logic          push_last;
  logic          pop_last;

  assign push_last = push & S_TLAST;
  assign pop_last  = pop & M_TLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pkt_cnt <= '0;
      flush   <= 1'b0;
    end else begin
      unique case ({push_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      // A full FIFO with no complete packet would otherwise deadlock.
      // Stream the oversized packet out until its TLAST beat is popped.
      if (pop_last) begin
        flush <= 1'b0;
      end else if ((level == LW'(DEPTH)) && (pkt_cnt == '0)) begin
        flush <= 1'b1;
      end
    end
  end

  assign m_tvalid = (level != '0) && ((pkt_cnt != '0) || flush);
`else
  assign m_tvalid = (level != '0);
`endif

endmodule
